// File: rtl/grid_game_pkg.sv
// Shared types and constants for the light-cycle grid engine.
package grid_game_pkg;

  localparam int unsigned CODE_W  = 3;
  localparam int unsigned COORD_W = 7;

  localparam logic [CODE_W-1:0] CELL_EMPTY = 3'd0;
  localparam logic [CODE_W-1:0] CELL_WALL  = 3'd7;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_SPAWN,
    ST_PLAY,
    ST_RD,
    ST_RESOLVE,
    ST_WR,
    ST_OVER
  } state_t;

  // Rotate a heading one quarter turn clockwise or counter-clockwise.
  function automatic dir_t turn_dir(input dir_t d, input logic cw);
    logic [1:0] raw;
    raw = cw ? (d + 2'd1) : (d - 2'd1);
    return dir_t'(raw);
  endfunction

endpackage

// File: rtl/grid_ram.sv
// Dual-port grid cell store: port A engine read/write, port B pixel read.
module grid_ram
  import grid_game_pkg::*;
#(
  parameter int unsigned DEPTH = 4800,
  parameter int unsigned AW    = 13
) (
  input  logic              clk_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic              a_we_i,
  input  logic [CODE_W-1:0] a_wdata_i,
  output logic [CODE_W-1:0] a_rdata_o,
  input  logic [AW-1:0]     b_addr_i,
  output logic [CODE_W-1:0] b_rdata_o
);

  logic [CODE_W-1:0] mem_q [DEPTH];

  // Synchronous write plus registered reads; reads see pre-write contents.
  always_ff @(posedge clk_i) begin
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    a_rdata_o <= mem_q[a_addr_i];
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/grid_game_engine.sv
// Light-cycle game engine: grid state, head movement, collisions, pixel port.
module grid_game_engine
  import grid_game_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned GRID_W      = 80,
  parameter int unsigned GRID_H      = 60,
  parameter int unsigned CELL_SHIFT  = 3,
  parameter int unsigned BORDER      = 2,
  parameter int unsigned TICK_CYCLES = 1000000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 reiniciar,
  input  logic [N_PLAYERS-1:0] turn_cw,
  input  logic [N_PLAYERS-1:0] turn_ccw,
  input  logic [9:0]           next_x,
  input  logic [9:0]           next_y,
  output logic [2:0]           pix_cell,
  output logic [N_PLAYERS-1:0] pix_head,
  output logic [N_PLAYERS-1:0] alive,
  output logic                 game_over,
  output logic [2:0]           winner,
  output logic                 busy
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned TW    = $clog2(TICK_CYCLES + 1);
  localparam int unsigned IW    = 3;
  localparam logic [COORD_W-1:0] SPAWN_ROW = COORD_W'(GRID_H / 2);

  function automatic logic [COORD_W-1:0] spawn_col(input int i);
    return COORD_W'((i + 1) * GRID_W / (N_PLAYERS + 1));
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  logic                 rst;
  state_t               state_q;
  logic [COORD_W-1:0]   clr_x_q, clr_y_q;
  logic [IW-1:0]        idx_q;
  logic [TW-1:0]        tick_q;
  logic [COORD_W-1:0]   head_x_q [N_PLAYERS];
  logic [COORD_W-1:0]   head_y_q [N_PLAYERS];
  dir_t                 dir_q    [N_PLAYERS];
  logic [N_PLAYERS-1:0] dying_q, alive_q, pend_v_q, pend_cw_q, cw_prev_q, ccw_prev_q;
  logic                 game_over_q, busy_q, in_grid_q;
  logic [2:0]           winner_q;
  logic [N_PLAYERS-1:0] pix_head_q;

  logic [COORD_W-1:0]   nxt_x [N_PLAYERS];
  logic [COORD_W-1:0]   nxt_y [N_PLAYERS];
  logic                 tick_done, on_border, sel_alive, in_grid;
  logic [COORD_W-1:0]   sel_nx, sel_ny, sel_sx, pcx, pcy;
  logic [N_PLAYERS-1:0] cw_rise, ccw_rise, turn_new, kill, alive_n;
  logic [2:0]           n_alive, win;
  logic [AW-1:0]        a_addr, b_addr;
  logic                 a_we;
  logic [CODE_W-1:0]    a_wdata, ram_a_rdata, ram_b_rdata;

  assign rst       = reset | reiniciar;
  assign tick_done = (state_q == ST_PLAY) && (tick_q == TW'(TICK_CYCLES - 1));
  assign cw_rise   = turn_cw & ~cw_prev_q;
  assign ccw_rise  = turn_ccw & ~ccw_prev_q;
  assign turn_new  = cw_rise ^ ccw_rise;
  assign on_border = (clr_x_q < COORD_W'(BORDER)) || (clr_x_q >= COORD_W'(GRID_W - BORDER)) ||
                     (clr_y_q < COORD_W'(BORDER)) || (clr_y_q >= COORD_W'(GRID_H - BORDER));

  // Next cell of every head along its current heading.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      nxt_x[i] = head_x_q[i];
      nxt_y[i] = head_y_q[i];
      case (dir_q[i])
        DIR_RIGHT: nxt_x[i] = head_x_q[i] + COORD_W'(1);
        DIR_DOWN:  nxt_y[i] = head_y_q[i] + COORD_W'(1);
        DIR_LEFT:  nxt_x[i] = head_x_q[i] - COORD_W'(1);
        default:   nxt_y[i] = head_y_q[i] - COORD_W'(1);
      endcase
    end
  end

  // Per-player fields selected by the shared sequencing index.
  always_comb begin
    sel_alive = 1'b0;
    sel_nx    = '0;
    sel_ny    = '0;
    sel_sx    = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_alive = alive_q[i];
        sel_nx    = nxt_x[i];
        sel_ny    = nxt_y[i];
        sel_sx    = spawn_col(i);
      end
    end
  end

  // Engine port of the grid RAM; a restart suppresses any write in flight.
  always_comb begin
    a_addr  = '0;
    a_we    = 1'b0;
    a_wdata = CELL_EMPTY;
    case (state_q)
      ST_CLEAR: begin
        a_addr  = cell_addr(clr_x_q, clr_y_q);
        a_we    = 1'b1;
        a_wdata = on_border ? CELL_WALL : CELL_EMPTY;
      end
      ST_SPAWN: begin
        a_addr  = cell_addr(sel_sx, SPAWN_ROW);
        a_we    = 1'b1;
        a_wdata = CODE_W'(idx_q + IW'(1));
      end
      ST_RD: a_addr = cell_addr(sel_nx, sel_ny);
      ST_WR: begin
        a_addr  = cell_addr(sel_nx, sel_ny);
        a_we    = sel_alive;
        a_wdata = CODE_W'(idx_q + IW'(1));
      end
      default: ;
    endcase
    if (rst) a_we = 1'b0;
  end

  // Head-on detection and survivor count for the resolve step.
  always_comb begin
    kill = dying_q;
    for (int i = 0; i < N_PLAYERS; i++) begin
      for (int j = i + 1; j < N_PLAYERS; j++) begin
        if (alive_q[i] && alive_q[j] && nxt_x[i] == nxt_x[j] && nxt_y[i] == nxt_y[j]) begin
          kill[i] = 1'b1;
          kill[j] = 1'b1;
        end
      end
    end
    alive_n = alive_q & ~kill;
    n_alive = '0;
    win     = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (alive_n[i]) begin
        n_alive = n_alive + 3'd1;
        win     = 3'(i + 1);
      end
    end
  end

  // Game sequencer: clear, spawn, tick, read targets, resolve, write heads.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
      idx_q       <= '0;
      tick_q      <= '0;
      dying_q     <= '0;
      alive_q     <= '1;
      game_over_q <= 1'b0;
      winner_q    <= '0;
      busy_q      <= 1'b1;
      for (int i = 0; i < N_PLAYERS; i++) begin
        head_x_q[i] <= spawn_col(i);
        head_y_q[i] <= SPAWN_ROW;
        dir_q[i]    <= (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
      end
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_x_q == COORD_W'(GRID_W - 1)) begin
            clr_x_q <= '0;
            if (clr_y_q == COORD_W'(GRID_H - 1)) begin
              clr_y_q <= '0;
              idx_q   <= '0;
              state_q <= ST_SPAWN;
            end else begin
              clr_y_q <= clr_y_q + COORD_W'(1);
            end
          end else begin
            clr_x_q <= clr_x_q + COORD_W'(1);
          end
        end
        ST_SPAWN: begin
          if (idx_q == IW'(N_PLAYERS - 1)) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_PLAY;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_PLAY: begin
          if (tick_done) begin
            tick_q  <= '0;
            idx_q   <= '0;
            dying_q <= '0;
            state_q <= ST_RD;
            for (int i = 0; i < N_PLAYERS; i++) begin
              if (pend_v_q[i]) dir_q[i] <= turn_dir(dir_q[i], pend_cw_q[i]);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        ST_RD: begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (idx_q == IW'(i + 1) && alive_q[i] && ram_a_rdata != CELL_EMPTY) dying_q[i] <= 1'b1;
          end
          if (idx_q == IW'(N_PLAYERS)) begin
            idx_q   <= '0;
            state_q <= ST_RESOLVE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_RESOLVE: begin
          alive_q <= alive_n;
          idx_q   <= '0;
          if (n_alive <= 3'd1) begin
            game_over_q <= 1'b1;
            winner_q    <= win;
            state_q     <= ST_OVER;
          end else begin
            state_q <= ST_WR;
          end
        end
        ST_WR: begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (idx_q == IW'(i) && alive_q[i]) begin
              head_x_q[i] <= nxt_x[i];
              head_y_q[i] <= nxt_y[i];
            end
          end
          if (idx_q == IW'(N_PLAYERS - 1)) begin
            idx_q   <= '0;
            state_q <= ST_PLAY;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_OVER: ;
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Turn edge detection; one pending turn per player, consumed at tick end.
  always_ff @(posedge CLOCK_50) begin
    cw_prev_q  <= turn_cw;
    ccw_prev_q <= turn_ccw;
    if (rst) begin
      pend_v_q  <= '0;
      pend_cw_q <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (tick_done) begin
          pend_v_q[i]  <= turn_new[i];
          pend_cw_q[i] <= cw_rise[i];
        end else if (!pend_v_q[i] && turn_new[i]) begin
          pend_v_q[i]  <= 1'b1;
          pend_cw_q[i] <= cw_rise[i];
        end
      end
    end
  end

  assign pcx     = COORD_W'(next_x >> CELL_SHIFT);
  assign pcy     = COORD_W'(next_y >> CELL_SHIFT);
  assign in_grid = (pcx < COORD_W'(GRID_W)) && (pcy < COORD_W'(GRID_H));
  assign b_addr  = in_grid ? cell_addr(pcx, pcy) : '0;

  // Pixel-side registers aligned with the RAM's one-cycle read.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      in_grid_q  <= 1'b0;
      pix_head_q <= '0;
    end else begin
      in_grid_q <= in_grid;
      for (int i = 0; i < N_PLAYERS; i++) begin
        pix_head_q[i] <= in_grid && pcx == head_x_q[i] && pcy == head_y_q[i];
      end
    end
  end

  grid_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk_i     (CLOCK_50),
    .a_addr_i  (a_addr),
    .a_we_i    (a_we),
    .a_wdata_i (a_wdata),
    .a_rdata_o (ram_a_rdata),
    .b_addr_i  (b_addr),
    .b_rdata_o (ram_b_rdata)
  );

  assign pix_cell  = in_grid_q ? ram_b_rdata : CELL_EMPTY;
  assign pix_head  = pix_head_q;
  assign alive     = alive_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign busy      = busy_q;

endmodule

// File: doc/grid_game_engine.md
Name: grid_game_engine

Overview:
Parametrised light-cycle game engine for 2..4 players on a cell grid.
- Holds the grid state: wall, empty, or player trail.
- Advances every head one cell per game tick.
- Detects wall, trail and head-on collisions, and declares game over with a winner.
- Serves a registered per-pixel cell-code read port to the VGA compositor.
- Sits between the key inputs and the VGA colour mux, driven by the VGA timing block's next_x/next_y.

Parameters:
N_PLAYERS, 2, number of players (2..4)
GRID_W, 80, grid columns
GRID_H, 60, grid rows
CELL_SHIFT, 3, log2 of cell size in pixels (8x8 cells)
BORDER, 2, wall thickness in cells (>=1)
TICK_CYCLES, 1000000, clock cycles per game step

Ports:
CLOCK_50  in  1  system clock, single clock domain
reset  in  1  synchronous reset, active-high
reiniciar  in  1  synchronous restart request, active-high, level
turn_cw  in  N_PLAYERS  per-player clockwise turn, active-high level, edge-detected internally
turn_ccw  in  N_PLAYERS  per-player counter-clockwise turn, same rules as turn_cw
next_x  in  10  pixel x of next pixel drawn
next_y  in  10  pixel y of next pixel drawn
pix_cell  out  3  cell code at (next_x,next_y): 0 empty, 1..N player trail, 7 wall
pix_head  out  N_PLAYERS  bit i set when the pixel lies in player i's current head cell
alive  out  N_PLAYERS  per-player alive flags
game_over  out  1  match ended, held until restart
winner  out  3  sole survivor index+1; 0 = draw; valid when game_over
busy  out  1  high during CLEAR/SPAWN

Behaviour:
- One clock; reset is synchronous and active-high, clock port CLOCK_50, reset port reset.
- Reset values:
  - pix_cell=0, pix_head=0, alive=all ones, game_over=0, winner=0, busy=1.
  - Tick counter=0, pending turns cleared, state=CLEAR.
- reiniciar has the same effect as reset on the engine. Either one asserted in any state, mid-step included, aborts at once. Any writes not yet done are dropped.
- Directions: 0 right, 1 down, 2 left, 3 up. CW is +1 mod 4; CCW is -1 mod 4.
- Spawn position for player i: column (i+1)*GRID_W/(N_PLAYERS+1) (integer division), row GRID_H/2.
- Spawn direction: right for even i, left for odd i.
- States:
  - CLEAR: writes one cell per cycle, row-major, GRID_W*GRID_H cycles. A cell inside the BORDER ring gets 7, otherwise 0. Then SPAWN.
  - SPAWN: writes code i+1 at each spawn cell, one per cycle (N_PLAYERS cycles). busy drops on exit. Then PLAY.
  - PLAY: tick counter counts 0..TICK_CYCLES-1. At terminal count it wraps to 0 and goes to RD.
  - RD: applies pending turns, computes each alive player's next cell, and reads it (synchronous 1-cycle read). Takes N_PLAYERS+1 cycles. A nonzero read marks that player dying.
  - RESOLVE (1 cycle):
    - Two alive players with equal next cells both die.
    - alive is updated.
    - If popcount(alive)<=1: game_over=1, winner=index+1 of survivor (0 if none), go to OVER. Otherwise go to WR.
  - WR: each surviving player writes code i+1 at its next cell and moves its head there, one per cycle. Then PLAY.
  - OVER: grid frozen, pixel port still active, outputs held until reset/reiniciar.
- Swap collision (heads exchange cells) is a death for both, because the target cells already hold trail.
- Dead players stop moving; their trail remains.
- Turn input handling:
  - A rising edge sets a pending turn if none is pending for that player; later edges are ignored until it is applied.
  - CW and CCW rising in the same cycle are both ignored.
  - At most one turn is applied per tick.
- Pixel port:
  - cell = (next_x>>CELL_SHIFT, next_y>>CELL_SHIFT).
  - pix_cell and pix_head are registered with 1-cycle latency.
  - A cell outside the grid reads 0.
  - Read-during-write returns the old data.
- Width rules: cell coordinates are 7 bits. No wrap-around is possible, because BORDER>=1 guarantees a wall hit first.

Decomposition:
- Package grid_game_pkg:
  - cell codes CELL_EMPTY=0 and CELL_WALL=7
  - direction encoding
  - state enum {CLEAR,SPAWN,PLAY,RD,RESOLVE,WR,OVER}
  - CODE_W=3
- Sub-module grid_ram: GRID_W*GRID_H x 3-bit memory.
  - Port A: engine read/write.
  - Port B: pixel read-only.
  - Both synchronous, 1-cycle read.

Test Plan:
Params for all scenarios: GRID_W=16, GRID_H=12, BORDER=1, TICK_CYCLES=4, N_PLAYERS=2. Spawns are (5,6) and (10,6).
1. Release reset -> busy high exactly 192+2 cycles. Then pix at (0,0) gives pix_cell=7 one cycle later. Pix at (40,48) gives pix_cell=1 and pix_head=01. Pix at (200,0) gives 0.
2. No input -> heads 6/9 after step 1, 7/8 after step 2. Step 3 swaps -> alive=00, game_over=1, winner=0. Grid unchanged afterwards.
3. GRID_W=12 (spawns 4,8) -> both target (6,6) at step 2 -> alive=00, winner=0.
4. Pulse turn_ccw on both players before step 1 -> p0 goes up, p1 goes down. p1 hits row 11 at step 5 -> alive=01, winner=1, game_over=1.
5. turn_cw[0] and turn_ccw[0] rise in the same cycle -> direction unchanged. Two cw edges within one tick -> exactly one turn applied.
6. Assert reiniciar during WR -> busy=1 next cycle, full CLEAR repeated, alive=11, game_over=0, no partial trail from the aborted step.
